// File: rtl/vga_sync_gen.sv
// VGA timing generator driven by an external raster counter: decodes sync/active
// regions, checks count continuity and gates video until locked to a frame start.
module vga_sync_gen #(
  parameter int unsigned W        = 12,
  parameter int unsigned H_ACTIVE = 1920,
  parameter int unsigned H_FP     = 88,
  parameter int unsigned H_SYNC   = 44,
  parameter int unsigned H_BP     = 349,
  parameter int unsigned V_ACTIVE = 1080,
  parameter int unsigned V_FP     = 4,
  parameter int unsigned V_SYNC   = 5,
  parameter int unsigned V_BP     = 312,
  parameter logic        HS_POL   = 1'b0,
  parameter logic        VS_POL   = 1'b0,
  parameter int unsigned FC_W     = 16
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [W-1:0]    i_h_cnt,
  input  logic [W-1:0]    i_v_cnt,
  output logic            o_hsync,
  output logic            o_vsync,
  output logic            o_de,
  output logic [W-1:0]    o_x,
  output logic [W-1:0]    o_y,
  output logic            o_line_start,
  output logic            o_frame_start,
  output logic            o_locked,
  output logic            o_seq_err,
  output logic [FC_W-1:0] o_frame_cnt
);

  localparam int unsigned H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned H_SYNC_LO = H_ACTIVE + H_FP;
  localparam int unsigned H_SYNC_HI = H_ACTIVE + H_FP + H_SYNC;
  localparam int unsigned V_SYNC_LO = V_ACTIVE + V_FP;
  localparam int unsigned V_SYNC_HI = V_ACTIVE + V_FP + V_SYNC;

  typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} state_t;

  state_t       state, next_state;
  logic [W-1:0] prev_h, prev_v;
  logic         prev_valid;
  logic [W-1:0] exp_h, exp_v;
  logic         err, h_act, h_sync, v_act, v_sync, nl, at_origin;

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= UNLOCKED;
    else       state <= next_state;
  end

  // Region decode, continuity check and lock next-state
  always_comb begin
    h_act      = i_h_cnt < W'(H_ACTIVE);
    h_sync     = (i_h_cnt >= W'(H_SYNC_LO)) && (i_h_cnt < W'(H_SYNC_HI));
    v_act      = i_v_cnt < W'(V_ACTIVE);
    v_sync     = (i_v_cnt >= W'(V_SYNC_LO)) && (i_v_cnt < W'(V_SYNC_HI));
    at_origin  = (i_h_cnt == '0) && (i_v_cnt == '0);
    exp_h      = '0;
    exp_v      = '0;
    if (prev_h < W'(H_TOTAL - 1)) begin
      exp_h = prev_h + W'(1);
      exp_v = prev_v;
    end else if (prev_v < W'(V_TOTAL - 1)) begin
      exp_v = prev_v + W'(1);
    end
    err = (prev_valid && ((i_h_cnt != exp_h) || (i_v_cnt != exp_v))) ||
          (i_h_cnt >= W'(H_TOTAL)) || (i_v_cnt >= W'(V_TOTAL));
    next_state = state;
    case (state)
      UNLOCKED: if (at_origin && !err) next_state = LOCKED;
      LOCKED:   if (err) next_state = UNLOCKED;
      default:  next_state = UNLOCKED;
    endcase
    nl = (next_state == LOCKED);
  end

  assign o_locked = (state == LOCKED);

  // Previous-sample history for the continuity check
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      prev_valid <= 1'b0;
      prev_h     <= '0;
      prev_v     <= '0;
    end else begin
      prev_valid <= 1'b1;
      prev_h     <= i_h_cnt;
      prev_v     <= i_v_cnt;
    end
  end

  // Registered timing outputs, gated by the next lock state
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_hsync       <= ~HS_POL;
      o_vsync       <= ~VS_POL;
      o_de          <= 1'b0;
      o_x           <= '0;
      o_y           <= '0;
      o_line_start  <= 1'b0;
      o_frame_start <= 1'b0;
      o_seq_err     <= 1'b0;
      o_frame_cnt   <= '0;
    end else begin
      o_hsync       <= (nl && h_sync) ? HS_POL : ~HS_POL;
      o_vsync       <= (nl && v_sync) ? VS_POL : ~VS_POL;
      o_de          <= nl && h_act && v_act;
      o_x           <= (nl && h_act && v_act) ? i_h_cnt : '0;
      o_y           <= (nl && h_act && v_act) ? i_v_cnt : '0;
      o_line_start  <= nl && (i_h_cnt == '0);
      o_frame_start <= nl && at_origin;
      o_seq_err     <= err;
      if (o_frame_start) o_frame_cnt <= o_frame_cnt + FC_W'(1);
    end
  end

endmodule
